// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier dispatcher
// FSM state encodings, default sizing and the queued operand entry layout.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    COOL  = 2'b11
  } state_e;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam int OP_W    = 8;
  localparam int RES_W   = 16;
  localparam int TAG_W   = 2;
  localparam int ENTRY_W = TAG_W + 2 * OP_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
  } entry_t;

endpackage

// File: rtl/booth_op_fifo.sv
// rtl/booth_op_fifo.sv - operand FIFO holding {tag, a, b} entries
// Power-of-two depth so pointers wrap naturally; head is read combinationally.
module booth_op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/booth_dispatch.sv
// rtl/booth_dispatch.sv - queues signed operand pairs and sequences them through a Booth multiplier
// One job at a time: IDLE -> ISSUE -> WAIT -> COOL, with a WAIT-cycle timeout that discards the job.
module booth_dispatch
  import booth_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  mul_result,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  tag_d;
  logic              mul_start_q;
  logic [OP_W-1:0]   mul_a_q;
  logic [OP_W-1:0]   mul_b_q;
  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign wr_entry = '{tag: tag_q, a: in_a, b: in_b};

  // The head leaves the queue only once its job finishes or is abandoned.
  assign pop = (state_q == WAIT) && (mul_done || (wait_cnt_q == TO_LAST));

  booth_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tag_d = push ? tag_q + TAG_W'(1) : tag_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mul_a_q     <= head.a;
          mul_b_q     <= head.b;
          mul_start_q <= 1'b1;
          wait_cnt_q  <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            res_data_q  <= mul_result;
            res_tag_q   <= head.tag;
            res_valid_q <= 1'b1;
            mul_start_q <= 1'b0;
            state_q     <= COOL;
          end else if (wait_cnt_q == TO_LAST) begin
            err_q       <= 1'b1;
            mul_start_q <= 1'b0;
            state_q     <= COOL;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        COOL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_booth_dispatch.sv
// tb/tb_booth_dispatch.sv - directed self-checking bench for booth_dispatch
// Behavioural multiplier with configurable done latency (0 = never completes).
module tb_booth_dispatch;

  localparam int TO = 64;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_tag;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int lat       = 1;
  bit spur_done = 0;
  int mcnt      = 0;
  logic signed [15:0] prod;

  int         rise_q [$];
  logic [7:0] a_q [$];
  logic [7:0] b_q [$];
  logic [15:0] rd_q [$];
  logic [1:0]  rt_q [$];
  int          rc_q [$];
  int          eq_q [$];
  int          unstable = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  prev_a = 8'h00;
  logic [7:0]  prev_b = 8'h00;

  int rb, db, eb, ub;

  booth_dispatch #(
    .DEPTH   (4),
    .TIMEOUT (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier model: raises done lat cycles after start is seen, drops it when start falls.
  always @(negedge clock) begin
    if (!mul_start) begin
      mcnt       = 0;
      mul_done   = spur_done;
      mul_result = spur_done ? 16'hBEEF : 16'h0000;
    end else begin
      mcnt = mcnt + 1;
      if (lat != 0 && mcnt >= lat) begin
        prod       = 16'($signed(mul_a)) * 16'($signed(mul_b));
        mul_done   = 1'b1;
        mul_result = prod;
      end else begin
        mul_done = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (mul_start && !prev_start) begin
      rise_q.push_back(cyc);
      a_q.push_back(mul_a);
      b_q.push_back(mul_b);
    end
    if (mul_start && prev_start && (mul_a != prev_a || mul_b != prev_b)) begin
      unstable = unstable + 1;
    end
    if (res_valid) begin
      rd_q.push_back(res_data);
      rt_q.push_back(res_tag);
      rc_q.push_back(cyc);
    end
    if (err) begin
      eq_q.push_back(cyc);
    end
    prev_start = mul_start;
    prev_a     = mul_a;
    prev_b     = mul_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic mark();
    rb = rise_q.size();
    db = rd_q.size();
    eb = eq_q.size();
    ub = unstable;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    mark();
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit stalled, output int pcyc);
    int n;
    n        = 0;
    stalled  = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 500) begin
      stalled = 1'b1;
      tick();
      n = n + 1;
    end
    check_eq("push_bound", 32'(n < 500), 32'd1);
    @(posedge clock);
    #1 pcyc = cyc;
    tick();
  endtask

  task automatic wait_res(input int n, input int budget);
    int k;
    k = 0;
    while (rd_q.size() < db + n && k < budget) begin
      tick();
      k = k + 1;
    end
  endtask

  task automatic check_gaps(input string tag);
    for (int i = rb + 1; i < rise_q.size(); i++) begin
      check_eq(tag, 32'(rise_q[i] - rise_q[i-1] >= 3), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit st;
    bit any_st;
    int pc;
    int k;
    int r0;
    logic [15:0] exp_burst [4];
    logic [15:0] exp_full [6];
    logic [1:0]  exp_ftag [6];
    logic [7:0]  fa [6];
    logic [7:0]  fb [6];

    exp_burst = '{16'hFFF6, 16'h0001, 16'h0001, 16'hFFC9};
    fa        = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'hFF};
    fb        = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h02};
    exp_full  = '{16'h0002, 16'h000C, 16'h001E, 16'h0038, 16'h005A, 16'hFFFE};
    exp_ftag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    do_reset();

    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mul_start", 32'(mul_start), 32'd0);
    check_eq("rst_mul_a", 32'(mul_a), 32'd0);
    check_eq("rst_mul_b", 32'(mul_b), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_data", 32'(res_data), 32'd0);
    check_eq("rst_res_tag", 32'(res_tag), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Single job
    lat = 1;
    push_pair(8'hF8, 8'hFB, st, pc);
    in_valid = 1'b0;
    wait_res(1, 50);
    check_eq("single_count", 32'(rd_q.size() - db), 32'd1);
    check_eq("single_starts", 32'(rise_q.size() - rb), 32'd1);
    if (rise_q.size() > rb) begin
      check_eq("single_start_lat", 32'(rise_q[rb] - pc), 32'd2);
      check_eq("single_mul_a", 32'(a_q[rb]), 32'h00F8);
      check_eq("single_mul_b", 32'(b_q[rb]), 32'h00FB);
      if (rd_q.size() > db) begin
        check_eq("single_done_lat", 32'(rc_q[db] - rise_q[rb]), 32'd1);
      end
    end
    if (rd_q.size() > db) begin
      check_eq("single_data", 32'(rd_q[db]), 32'h0028);
      check_eq("single_tag", 32'(rt_q[db]), 32'd0);
    end
    repeat (6) tick();
    check_eq("hold_data", 32'(res_data), 32'h0028);
    check_eq("hold_tag", 32'(res_tag), 32'd0);
    check_eq("single_one_pulse", 32'(rd_q.size() - db), 32'd1);
    check_eq("single_stable", 32'(unstable - ub), 32'd0);

    // Burst of four
    do_reset();
    lat = 1;
    any_st = 1'b0;
    push_pair(8'h05, 8'hFE, st, pc); any_st = any_st | st;
    push_pair(8'hFF, 8'hFF, st, pc); any_st = any_st | st;
    push_pair(8'h01, 8'h01, st, pc); any_st = any_st | st;
    push_pair(8'h05, 8'hF5, st, pc); any_st = any_st | st;
    in_valid = 1'b0;
    check_eq("burst_ready", 32'(any_st), 32'd0);
    wait_res(4, 100);
    check_eq("burst_count", 32'(rd_q.size() - db), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rd_q.size() > db + i) begin
        check_eq($sformatf("burst_data%0d", i), 32'(rd_q[db+i]), 32'(exp_burst[i]));
        check_eq($sformatf("burst_tag%0d", i), 32'(rt_q[db+i]), 32'(i));
      end
    end
    check_gaps("burst_gap");
    check_eq("burst_stable", 32'(unstable - ub), 32'd0);

    // Full FIFO with slow multiplier
    do_reset();
    lat = 20;
    for (int i = 0; i < 6; i++) begin
      push_pair(fa[i], fb[i], st, pc);
      if (i == 3) begin
        check_eq("full_ready_low", 32'(in_ready), 32'd0);
      end
      if (i == 4) begin
        check_eq("full_fifth_stalled", 32'(st), 32'd1);
      end
    end
    in_valid = 1'b0;
    wait_res(6, 400);
    check_eq("full_count", 32'(rd_q.size() - db), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (rd_q.size() > db + i) begin
        check_eq($sformatf("full_data%0d", i), 32'(rd_q[db+i]), 32'(exp_full[i]));
        check_eq($sformatf("full_tag%0d", i), 32'(rt_q[db+i]), 32'(exp_ftag[i]));
      end
    end
    check_gaps("full_gap");
    check_eq("full_stable", 32'(unstable - ub), 32'd0);

    // Timeout then recovery
    do_reset();
    lat = 0;
    push_pair(8'h02, 8'h03, st, pc);
    push_pair(8'h04, 8'h05, st, pc);
    in_valid = 1'b0;
    k = 0;
    while (eq_q.size() == eb && k < 200) begin
      tick();
      k = k + 1;
    end
    check_eq("to_err_seen", 32'(eq_q.size() - eb), 32'd1);
    check_eq("to_no_result", 32'(rd_q.size() - db), 32'd0);
    if (eq_q.size() > eb && rise_q.size() > rb) begin
      check_eq("to_err_delay", 32'(eq_q[eb] - rise_q[rb]), 32'(TO));
    end
    lat = 1;
    wait_res(1, 50);
    check_eq("to_next_count", 32'(rd_q.size() - db), 32'd1);
    if (rd_q.size() > db) begin
      check_eq("to_next_data", 32'(rd_q[db]), 32'h0014);
      check_eq("to_next_tag", 32'(rt_q[db]), 32'd1);
    end
    if (rise_q.size() > rb + 1) begin
      check_eq("to_next_mul_a", 32'(a_q[rb+1]), 32'h0004);
      check_eq("to_next_mul_b", 32'(b_q[rb+1]), 32'h0005);
    end
    check_eq("to_err_once", 32'(eq_q.size() - eb), 32'd1);

    // Reset in the middle of WAIT with two entries queued
    do_reset();
    lat = 0;
    push_pair(8'h11, 8'h22, st, pc);
    push_pair(8'h33, 8'h44, st, pc);
    push_pair(8'h55, 8'h66, st, pc);
    in_valid = 1'b0;
    repeat (4) tick();
    check_eq("mid_pre_start", 32'(mul_start), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check_eq("mid_mul_start", 32'(mul_start), 32'd0);
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_res_valid", 32'(res_valid), 32'd0);
    check_eq("mid_err", 32'(err), 32'd0);
    r0 = rise_q.size();
    repeat (80) tick();
    check_eq("mid_no_issue", 32'(rise_q.size() - r0), 32'd0);
    check_eq("mid_no_err", 32'(eq_q.size() - eb), 32'd0);
    check_eq("mid_no_result", 32'(rd_q.size() - db), 32'd0);

    // Spurious done while idle and empty
    do_reset();
    lat = 1;
    spur_done = 1'b1;
    repeat (4) tick();
    spur_done = 1'b0;
    repeat (3) tick();
    check_eq("spur_no_result", 32'(rd_q.size() - db), 32'd0);
    check_eq("spur_no_issue", 32'(rise_q.size() - rb), 32'd0);
    check_eq("spur_res_data", 32'(res_data), 32'd0);
    check_eq("spur_mul_start", 32'(mul_start), 32'd0);
    check_eq("spur_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_dispatch.md
BOOTH_DISPATCH -- requirements
Module: booth_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand FIFO entries (power of two, minimum 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before abort.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the FIFO can accept a pair.
REQ-007 SHALL have ports in_a and in_b, input, 8 bits each: signed multiplicand and signed multiplier.
REQ-008 SHALL have port mul_start, output, 1 bit: start level to the Booth multiplier.
REQ-009 SHALL have ports mul_a and mul_b, output, 8 bits each: operands to the multiplier (a_value, b_value).
REQ-010 SHALL have port mul_done, input, 1 bit: multiplier completion.
REQ-011 SHALL have port mul_result, input, 16 bits: multiplier product.
REQ-012 SHALL have port res_valid, output, 1 bit: one-cycle pulse when a product is delivered.
REQ-013 SHALL have port res_data, output, 16 bits: the captured product.
REQ-014 SHALL have port res_tag, output, 2 bits: sequence tag of the delivered product.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on timeout abort.

Function
REQ-016 SHALL store {tag, in_a, in_b} in the FIFO on a push, where push = in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH), with count ranging 0..DEPTH.
REQ-018 SHALL assign each push a tag from a 2-bit counter that increments per push and wraps 3->0.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and keep the data of both operations intact.
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT and COOL.
REQ-021 SHALL move IDLE->ISSUE when count != 0, and stay in IDLE otherwise.
REQ-022 SHALL, in ISSUE, register the head pair onto mul_a/mul_b, set mul_start=1, and go to WAIT.
REQ-023 SHALL hold mul_start=1 and mul_a/mul_b stable throughout WAIT.
REQ-024 SHALL, in WAIT with mul_done=1, capture mul_result into res_data and the head tag into res_tag, pulse res_valid the next cycle, pop the FIFO, clear mul_start, and go to COOL.
REQ-025 SHALL count cycles in WAIT; if the count reaches TIMEOUT-1 without mul_done, it SHALL pulse err for one cycle, pop (discard) the head entry, assert no res_valid, clear mul_start, and go to COOL.
REQ-026 SHALL spend exactly one cycle in COOL with mul_start=0, then go to IDLE, so that the multiplier returns to its idle state.
REQ-027 SHALL ignore mul_done outside WAIT.
REQ-028 SHALL hold res_data and res_tag until the next delivery.
REQ-029 SHALL achieve minimum latency push->mul_start of 2 cycles (FIFO write, then ISSUE), and mul_done->res_valid of 1 cycle.
REQ-030 SHALL issue back-to-back jobs no closer than 3 cycles between mul_start rising edges.
REQ-031 SHALL pass operands and products through unmodified, with no sign or width conversion.

Reset
REQ-032 SHALL, with reset=1 at a clock edge, set the FSM to IDLE, clear count, FIFO pointers, tag counter, timeout counter, mul_start, mul_a, mul_b, res_valid, res_data, res_tag and err to 0, and set in_ready=1 from the next cycle.
REQ-033 SHALL, if reset occurs mid-job (ISSUE, WAIT or COOL), drop the job and all queued entries without pulsing res_valid or err.
REQ-034 SHALL give reset priority over push, pop and mul_done in the same cycle.

Structure
REQ-035 SHALL place the FSM state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, COOL=2'b11) and the default DEPTH/TIMEOUT constants in the shared booth_pkg.
REQ-036 SHALL implement the FIFO as sub-module booth_op_fifo (parameterised DEPTH, width 18), with the FSM in the top level.

Verification (bench uses a behavioural multiplier model with a configurable done latency)
REQ-037 SHALL check a single job: push a=F8, b=FB -> mul_start rises 2 cycles later with mul_a=F8, mul_b=FB; res_valid pulses once with res_data=0028, res_tag=0.
REQ-038 SHALL check a burst: push {05,FE}, {FF,FF}, {01,01}, {05,F5} on consecutive cycles -> results FFF6, 0001, 0001, FFC9 delivered in order with tags 0..3; in_ready stays 1.
REQ-039 SHALL check full: model latency 20 and 6 back-to-back pushes -> in_ready=0 when count reaches 4; no entry is lost; the tag wraps to 0 on the fifth push.
REQ-040 SHALL check timeout: model never asserts done -> err pulses exactly TIMEOUT cycles after entering WAIT, no res_valid, and the next entry is issued afterwards.
REQ-041 SHALL check reset mid-WAIT with 2 queued entries -> the next cycle shows mul_start=0, in_ready=1, no res_valid or err, and the FIFO is empty.
REQ-042 SHALL check a spurious mul_done=1 while in IDLE with the FIFO empty -> no res_valid and no state change.
